// File: rtl/seq_add16_ctrl.sv
// Nibble-serial adder/subtractor: one shared 4-bit ripple slice processes
// one nibble per clock, LSB first, and reports carry and signed overflow.
module seq_add16_ctrl #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [4*NIB-1:0] a,
    input  logic [4*NIB-1:0] b,
    output logic [4*NIB-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int W  = 4 * NIB;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_r, b_r;
    logic            sub_r, cin_r;
    logic [IW-1:0]   idx;
    logic            carry;

    logic            last_nib;
    logic [3:0]      slice_a, slice_b, slice_sum;
    logic [4:0]      slice_c;

    assign last_nib = (idx == IW'(NIB - 1));

    // Nibble 0 takes cin in add mode and a forced 1 in subtract mode.
    always_comb begin
        slice_a    = a_r[4*idx +: 4];
        slice_b    = b_r[4*idx +: 4] ^ {4{sub_r}};
        slice_c    = '0;
        slice_c[0] = (idx == '0) ? (sub_r | cin_r) : carry;
        slice_sum  = '0;
        for (int i = 0; i < 4; i++) begin
            slice_sum[i]   = slice_a[i] ^ slice_b[i] ^ slice_c[i];
            slice_c[i+1]   = (slice_a[i] & slice_b[i]) | (slice_c[i] & (slice_a[i] ^ slice_b[i]));
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (last_nib) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ADD);
        done = (state == DONE);
    end

    // Operands latch only on an accepted start, so start during ADD/DONE is inert.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            sub_r <= 1'b0;
            cin_r <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        sub_r <= sub;
                        cin_r <= cin;
                        idx   <= '0;
                    end
                end
                ADD: begin
                    sum[4*idx +: 4] <= slice_sum;
                    carry           <= slice_c[4];
                    if (last_nib) begin
                        cout <= slice_c[4];
                        ovf  <= slice_c[3] ^ slice_c[4];
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_add16_ctrl.sv
// Directed self-checking bench for seq_add16_ctrl (NIB = 4) with
// hand-computed sums, carries, overflow flags and handshake timing.
module tb_seq_add16_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    seq_add16_ctrl #(.NIB(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Callers sit 1ns after a rising edge; start is sampled at the next edge (N).
    task automatic do_start(input logic s, input logic c, input logic [15:0] av, input logic [15:0] bv);
        sub   = s;
        cin   = c;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Entered 1ns after edge N; expects done after edge N+4 and a one-cycle pulse.
    task automatic wait_result(input string tag, input logic [15:0] es, input logic ec, input logic eo);
        int n        = 0;
        int busy_cnt = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, n, 4);
        check({tag, " busy_cycles"}, busy_cnt, 4);
        check({tag, " sum"}, sum, es);
        check({tag, " cout"}, cout, ec);
        check({tag, " ovf"}, ovf, eo);
        @(posedge clk);
        #1;
        check({tag, " done_pulse_end"}, done, 0);
        check({tag, " sum_hold"}, sum, es);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("reset sum", sum, 0);
        check("reset flags", {cout, ovf, busy, done}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_start(1'b0, 1'b0, 16'h1234, 16'h4321);
        wait_result("add", 16'h5555, 1'b0, 1'b0);
        do_start(1'b0, 1'b0, 16'hFFFF, 16'h0001);
        wait_result("carry_chain", 16'h0000, 1'b1, 1'b0);
        do_start(1'b0, 1'b0, 16'h7FFF, 16'h0001);
        wait_result("pos_ovf", 16'h8000, 1'b0, 1'b1);
        do_start(1'b1, 1'b1, 16'h0005, 16'h0007);
        wait_result("sub_cin1", 16'hFFFE, 1'b0, 1'b0);
        do_start(1'b1, 1'b0, 16'h0005, 16'h0007);
        wait_result("sub_cin0", 16'hFFFE, 1'b0, 1'b0);
        do_start(1'b0, 1'b1, 16'h000F, 16'h0000);
        wait_result("add_cin", 16'h0010, 1'b0, 1'b0);
        // Started in the IDLE cycle straight after the previous done.
        do_start(1'b1, 1'b0, 16'h8000, 16'h0001);
        wait_result("sub_ovf", 16'h7FFF, 1'b1, 1'b1);

        // Second start presented at edge N+2 must be ignored.
        do_start(1'b0, 1'b0, 16'h1234, 16'h4321);
        @(posedge clk);
        #1;
        a     = 16'h1111;
        b     = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                pulses++;
                check("busy_start sum", sum, 16'h5555);
            end
            @(posedge clk);
            #1;
        end
        check("busy_start done_pulses", pulses, 1);

        // Reset asserted after edge N+2 clears outputs without waiting for a clock.
        do_start(1'b1, 1'b0, 16'h8000, 16'h0001);
        do_start(1'b0, 1'b0, 16'h1234, 16'h4321);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset sum", sum, 0);
        check("midreset flags", {cout, ovf, busy, done}, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("midreset no_done", pulses, 0);
        rst_n = 1'b1;
        do_start(1'b0, 1'b0, 16'h7FFF, 16'h0001);
        wait_result("post_reset", 16'h8000, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
